updown_counter: RTL and testbench

//  Parametrised modulo counter; successor to the single-direction MAX_VALUE counter.

---
 rtl/counter_pkg.sv | 15 +
 rtl/tick_prescaler.sv | 34 +++
 rtl/updown_counter.sv | 111 +++++++++++
 tb/tb_updown_counter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down modulo counter family.
package counter_pkg;

  // Behaviour at the count limits: roll over, or clamp and keep flagging.
  typedef enum logic {
    CNT_WRAP,
    CNT_SATURATE
  } cnt_mode_t;

  // Width needed to hold 0..max_value; never less than one bit.
  function automatic int cnt_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the enable stream: one tick every PRESCALE enabled cycles.
// With PRESCALE=1 the count register stays at 0 and the tick equals i_en.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic i_clk,
  input  logic i_a_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  // Tick is combinational so the counter can act on it in the same cycle.
  always_comb begin
    o_tick = i_en && (cnt == LAST);
  end

  // Enabled-cycle counter; clear wins, disabled cycles freeze it.
  always_ff @(posedge i_clk or posedge i_a_rst) begin
    if (i_a_rst) begin
      cnt <= '0;
    end else if (i_clr) begin
      cnt <= '0;
    end else if (i_en) begin
      cnt <= o_tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Parametrised up/down modulo counter with step, parallel load, sync clear,
// wrap or saturate behaviour, optional prescaler and a terminal-count pulse.
module updown_counter
  import counter_pkg::*;
#(
  parameter int        MAX_VALUE = 255,
  parameter int        STEP      = 1,
  parameter cnt_mode_t MODE      = CNT_WRAP,
  parameter int        PRESCALE  = 1,
  localparam int       CW        = cnt_width(MAX_VALUE)
) (
  input  logic          i_clk,
  input  logic          i_a_rst,
  input  logic          i_en,
  input  logic          i_dir,
  input  logic          i_clr,
  input  logic          i_load,
  input  logic [CW-1:0] i_ld_val,
  output logic [CW-1:0] o_value,
  output logic          o_tc
);

  // One extra bit so v+STEP and v+MAX+1 never overflow before the limit test.
  localparam int CX = CW + 1;
  localparam logic [CX-1:0] STEP_X = CX'(STEP);
  localparam logic [CX-1:0] MAX_X  = CX'(MAX_VALUE);
  localparam logic [CX-1:0] MOD_X  = CX'(MAX_VALUE + 1);

  // Reject parameter sets that would make the arithmetic meaningless.
  if (MAX_VALUE < 1) begin : g_bad_max
    $fatal(1, "updown_counter: MAX_VALUE must be >= 1");
  end
  if (STEP < 1 || STEP > MAX_VALUE) begin : g_bad_step
    $fatal(1, "updown_counter: STEP must be in 1..MAX_VALUE");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $fatal(1, "updown_counter: PRESCALE must be >= 1");
  end

  logic          tick;
  logic [CX-1:0] v_ext;
  logic [CX-1:0] up_sum;
  logic          up_over;
  logic          down_under;
  logic [CW-1:0] nxt_value;
  logic          nxt_tc;
  logic [CW-1:0] ld_value;

  // Clear and load both restart the prescaler phase.
  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .i_clk  (i_clk),
    .i_a_rst(i_a_rst),
    .i_en   (i_en),
    .i_clr  (i_clr | i_load),
    .o_tick (tick)
  );

  // Candidate next count and terminal-count flag for a count event.
  always_comb begin
    v_ext      = {1'b0, o_value};
    up_sum     = v_ext + STEP_X;
    up_over    = up_sum > MAX_X;
    down_under = v_ext < STEP_X;
    nxt_value  = o_value;
    nxt_tc     = 1'b0;
    if (MODE == CNT_SATURATE) begin
      if (i_dir) begin
        nxt_value = up_over ? CW'(MAX_X) : CW'(up_sum);
        nxt_tc    = up_sum >= MAX_X;
      end else begin
        nxt_value = down_under ? '0 : CW'(v_ext - STEP_X);
        nxt_tc    = v_ext <= STEP_X;
      end
    end else begin
      if (i_dir) begin
        nxt_value = up_over ? CW'(up_sum - MOD_X) : CW'(up_sum);
        nxt_tc    = up_over;
      end else begin
        nxt_value = down_under ? CW'(v_ext + MOD_X - STEP_X) : CW'(v_ext - STEP_X);
        nxt_tc    = down_under;
      end
    end
  end

  // Load value clamped to the legal range.
  always_comb begin
    ld_value = ({1'b0, i_ld_val} > MAX_X) ? CW'(MAX_X) : i_ld_val;
  end

  // Count register; priority is clear, load, count event, hold. o_tc is a pulse.
  always_ff @(posedge i_clk or posedge i_a_rst) begin
    if (i_a_rst) begin
      o_value <= '0;
      o_tc    <= 1'b0;
    end else if (i_clr) begin
      o_value <= '0;
      o_tc    <= 1'b0;
    end else if (i_load) begin
      o_value <= ld_value;
      o_tc    <= 1'b0;
    end else if (tick) begin
      o_value <= nxt_value;
      o_tc    <= nxt_tc;
    end else begin
      o_tc    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: five parameterisations share one input bus and
// are checked every cycle against an arithmetic reference model, plus
// directed vector tables and hand-written multi-cycle sequences.
module tb_updown_counter;
  import counter_pkg::*;

  localparam int N = 5;
  localparam int MAXV [N] = '{255, 9, 9, 200, 100};
  localparam int STEPV[N] = '{1, 3, 4, 7, 9};
  localparam int SATV [N] = '{0, 0, 1, 0, 1};
  localparam int PSV  [N] = '{1, 1, 1, 4, 3};
  localparam int CWV  [N] = '{8, 4, 4, 8, 7};

  // Clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en, dir, clr, load;
  logic [7:0] ld_val;
  logic [7:0] v0;
  logic [3:0] v1, v2;
  logic [7:0] v3;
  logic [6:0] v4;
  logic [N-1:0] tc;

  updown_counter #(.MAX_VALUE(255), .STEP(1), .MODE(CNT_WRAP), .PRESCALE(1)) u_c0 (
    .i_clk(clk), .i_a_rst(rst), .i_en(en), .i_dir(dir), .i_clr(clr), .i_load(load),
    .i_ld_val(ld_val), .o_value(v0), .o_tc(tc[0]));
  updown_counter #(.MAX_VALUE(9), .STEP(3), .MODE(CNT_WRAP), .PRESCALE(1)) u_c1 (
    .i_clk(clk), .i_a_rst(rst), .i_en(en), .i_dir(dir), .i_clr(clr), .i_load(load),
    .i_ld_val(ld_val[3:0]), .o_value(v1), .o_tc(tc[1]));
  updown_counter #(.MAX_VALUE(9), .STEP(4), .MODE(CNT_SATURATE), .PRESCALE(1)) u_c2 (
    .i_clk(clk), .i_a_rst(rst), .i_en(en), .i_dir(dir), .i_clr(clr), .i_load(load),
    .i_ld_val(ld_val[3:0]), .o_value(v2), .o_tc(tc[2]));
  updown_counter #(.MAX_VALUE(200), .STEP(7), .MODE(CNT_WRAP), .PRESCALE(4)) u_c3 (
    .i_clk(clk), .i_a_rst(rst), .i_en(en), .i_dir(dir), .i_clr(clr), .i_load(load),
    .i_ld_val(ld_val), .o_value(v3), .o_tc(tc[3]));
  updown_counter #(.MAX_VALUE(100), .STEP(9), .MODE(CNT_SATURATE), .PRESCALE(3)) u_c4 (
    .i_clk(clk), .i_a_rst(rst), .i_en(en), .i_dir(dir), .i_clr(clr), .i_load(load),
    .i_ld_val(ld_val[6:0]), .o_value(v4), .o_tc(tc[4]));

  function automatic int dut_val(input int i);
    case (i)
      0:       return int'(v0);
      1:       return int'(v1);
      2:       return int'(v2);
      3:       return int'(v3);
      default: return int'(v4);
    endcase
  endfunction

  // Reference model: per-instance count, prescaler phase and tc pulse
  int m_val[N];
  int m_pre[N];
  int m_tc [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_val[i] = 0;
      m_pre[i] = 0;
      m_tc[i]  = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      int lv, raw, m;
      bit tick;
      m = MAXV[i] + 1;
      if (clr) begin
        m_val[i] = 0; m_pre[i] = 0; m_tc[i] = 0;
      end else if (load) begin
        lv = int'(ld_val) % (1 << CWV[i]);
        m_val[i] = (lv > MAXV[i]) ? MAXV[i] : lv;
        m_pre[i] = 0; m_tc[i] = 0;
      end else if (en) begin
        tick = (m_pre[i] == PSV[i] - 1);
        m_pre[i] = tick ? 0 : m_pre[i] + 1;
        m_tc[i] = 0;
        if (tick) begin
          raw = dir ? m_val[i] + STEPV[i] : m_val[i] - STEPV[i];
          if (SATV[i] != 0) begin
            if (raw >= MAXV[i] && dir)  begin m_val[i] = MAXV[i]; m_tc[i] = 1; end
            else if (raw <= 0 && !dir)  begin m_val[i] = 0;       m_tc[i] = 1; end
            else m_val[i] = raw;
          end else begin
            m_val[i] = (raw + m) % m;
            m_tc[i]  = (raw >= m || raw < 0) ? 1 : 0;
          end
        end
      end else begin
        m_tc[i] = 0;
      end
    end
  endtask

  // Scoreboard
  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic e, input logic d, input logic c, input logic l,
                       input logic [7:0] lv);
    en = e; dir = d; clr = c; load = l; ld_val = lv;
  endtask

  // One clock: update model at the edge, compare all instances 1 ns later
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < N; i++) exp_q.push_back(8'(m_val[i]));
    for (int i = 0; i < N; i++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check($sformatf("model_val[%0d]", i), dut_val(i), int'(e));
      check($sformatf("model_tc[%0d]", i), int'(tc[i]), m_tc[i]);
    end
  endtask

  typedef struct {
    logic       en;
    logic       dir;
    logic       clr;
    logic       load;
    logic [7:0] ld;
    int         inst;
    int         exp_val;
    int         exp_tc;
  } vec_t;

  vec_t tbl[$];

  initial begin
    // Directed vectors: {en, dir, clr, load, ld_val, instance, value, tc}
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 8'd0,   0, 0,   0});
    // down wrap, MAX 9 STEP 3 from 0
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1, 7,   1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1, 4,   0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1, 1,   0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1, 8,   1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1, 5,   0});
    // saturate, MAX 9 STEP 4: up then down
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   2, 0,   0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   2, 4,   0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   2, 8,   0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   2, 9,   1});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   2, 9,   1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   2, 5,   0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   2, 1,   0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   2, 0,   1});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   2, 0,   1});
    // clear beats load beats count; load clamps to MAX
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 8'hFA,  0, 0,   0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 8'hFA,  3, 200, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 8'hFA,  1, 9,   0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'd5,   4, 5,   0});
    // prescale 3 saturating down from 5
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   4, 5,   0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   4, 5,   0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   4, 0,   1});

    // Reset state
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_val[%0d]", i), dut_val(i), 0);
      check($sformatf("reset_tc[%0d]", i), int'(tc[i]), 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].en, tbl[k].dir, tbl[k].clr, tbl[k].load, tbl[k].ld);
      step();
      check($sformatf("tbl%0d_val", k), dut_val(tbl[k].inst), tbl[k].exp_val);
      check($sformatf("tbl%0d_tc", k), int'(tc[tbl[k].inst]), tbl[k].exp_tc);
    end

    // Full up wrap of the 8-bit counter
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    for (int k = 1; k <= 256; k++) begin
      step();
      check("wrap255_val", dut_val(0), k % 256);
      check("wrap255_tc", int'(tc[0]), (k == 256) ? 1 : 0);
    end

    // Prescale 4 with a disabled stretch in the middle
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    repeat (6) step();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    repeat (5) step();
    check("prescale_frozen", dut_val(3), 7);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    repeat (6) step();
    check("prescale_three", dut_val(3), 21);

    // Async reset in the middle of a cycle at value 100
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'd0);
    repeat (100) step();
    check("pre_reset_val", dut_val(0), 100);
    #3 rst = 1'b1;
    #1;
    check("async_reset_val", dut_val(0), 0);
    check("async_reset_tc", int'(tc[0]), 0);
    #1 rst = 1'b0;
    model_reset();
    step();
    check("after_reset_val", dut_val(0), 1);

    // Randomised traffic against the model
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 49) == 0), ($urandom_range(0, 29) == 0),
            8'($urandom_range(0, 255)));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
